dma_reg_arbiter: RTL and testbench

Round-robin arbiter that shares the single DMA register-access bus (addr / wr_en / valid / wdata / rdata) among NUM_REQ requesters, such as the CPU config port and the descriptor sequencer. It accepts one request at a time and issues it as a one-cycle bus access. For reads it waits a fixed RD_LAT cycles, then returns a response to the owning requester. It sits between the requesters and the DMA register slave; its bus-side ports connect directly to the DMA interface signals.

---
 rtl/dma_reg_arbiter.sv | 149 ++++++++++++++
 tb/tb_dma_reg_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_arbiter.sv
// dma_reg_arbiter: round-robin arbiter sharing one DMA register-access bus
// among NUM_REQ requesters. One transaction outstanding at a time; writes
// complete one cycle after the bus strobe, reads RD_LAT cycles after that.
`timescale 1ns/1ps
module dma_reg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int RD_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_wr_en,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic [31:0]           addr,
   output logic                  wr_en,
   output logic                  valid,
   output logic [31:0]           wdata,
   input  logic [31:0]           rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   wr_q, wr_d;
   logic                   valid_q, valid_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [31:0]            rsp_rdata_q, rsp_rdata_d;

   logic [NUM_REQ-1:0][31:0] addr_a, wdata_a;
   logic [IDX_W-1:0]       win, cand;
   logic                   found;

   assign addr_a  = req_addr;
   assign wdata_a = req_wdata;

   // Round-robin search starting just after the last winner, so the most
   // recent winner is always examined last.
   always_comb begin
      found = 1'b0;
      win   = last_q;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state and output decode; last_q doubles as the owner of the
   // outstanding transaction since it only changes on a new grant.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      valid_d     = 1'b0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      req_ready   = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               req_ready[win] = 1'b1;
               addr_d         = addr_a[win];
               wdata_d        = wdata_a[win];
               wr_d           = req_wr_en[win];
               valid_d        = 1'b1;
               last_d         = win;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               rsp_valid_d[last_q] = 1'b1;
               rsp_rdata_d         = '0;
               state_d             = IDLE;
            end else begin
               cnt_d   = CNT_W'(RD_LAT);
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               rsp_rdata_d         = rdata;
               rsp_valid_d[last_q] = 1'b1;
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= IDX_W'(NUM_REQ - 1);
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         valid_q     <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         valid_q     <= valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign wr_en     = wr_q;
   assign valid     = valid_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

   // Requests must be held until accepted; grants and completions are one-hot.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
      a_hold: assert property (@(posedge clk) disable iff (!reset)
         req_valid[i] && !req_ready[i] |=> req_valid[i]);
   end
   a_rdy_1hot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
   a_rsp_1hot: assert property (@(posedge clk) disable iff (!reset) $onehot0(rsp_valid));

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Bench for dma_reg_arbiter: two instances (RD_LAT=1 and RD_LAT=3), a
// queue-driven requester driver, a slave model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_dma_reg_arbiter;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      int          idx;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   localparam int LAT [2] = '{1, 3};

   logic          clk;
   logic          rst_n;
   logic [3:0]    rv   [2];
   logic [3:0]    rw   [2];
   logic [127:0]  ra   [2];
   logic [127:0]  rwd  [2];
   logic [3:0]    rdy  [2];
   logic [3:0]    rspv [2];
   logic [31:0]   rrd  [2];
   logic [31:0]   baddr[2];
   logic [31:0]   bwd  [2];
   logic          bwr  [2];
   logic          bval [2];
   logic [31:0]   sdata[2];

   logic [3:0]    sv   [2];
   logic [31:0]   sa   [2][4];

   txn_t          sq   [8][$];
   logic          act  [8];
   exp_t          gq   [2][$];
   exp_t          bq   [2][$];
   exp_t          rq   [2][$];
   int            acc  [2];
   logic          busy [2];
   exp_t          me;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   dma_reg_arbiter #(.NUM_REQ(4), .RD_LAT(1)) u_dut1 (
      .clk(clk), .reset(rst_n),
      .req_valid(rv[0]), .req_wr_en(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
      .req_ready(rdy[0]), .rsp_valid(rspv[0]), .rsp_rdata(rrd[0]),
      .addr(baddr[0]), .wr_en(bwr[0]), .valid(bval[0]), .wdata(bwd[0]),
      .rdata(sdata[0]));

   dma_reg_arbiter #(.NUM_REQ(4), .RD_LAT(3)) u_dut3 (
      .clk(clk), .reset(rst_n),
      .req_valid(rv[1]), .req_wr_en(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
      .req_ready(rdy[1]), .rsp_valid(rspv[1]), .rsp_rdata(rrd[1]),
      .addr(baddr[1]), .wr_en(bwr[1]), .valid(bval[1]), .wdata(bwd[1]),
      .rdata(sdata[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave read data; outside the presentation cycle rdata carries a poison value.
   function automatic logic [31:0] slv(input logic [31:0] a);
      return (a == 32'h20) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   // Slave pipeline: stage k holds a read issued k+1 cycles ago.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         sv[d] <= {sv[d][2:0], bval[d] & ~bwr[d]};
         for (int k = 3; k > 0; k--) sa[d][k] <= sa[d][k-1];
         sa[d][0] <= baddr[d];
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++)
         sdata[d] = sv[d][LAT[d]-1] ? slv(sa[d][LAT[d]-1]) : 32'hBAD0_BAD0;
   end

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_chk++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act_v, exp_v, cyc);
      end
   endtask

   // Queue a request and its expected grant/bus/response, in grant order.
   task automatic req(input int d, input int i, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input bit rsp);
      txn_t t;
      exp_t e;
      t.wr = wr; t.addr = a; t.wdata = wd;
      sq[d*4+i].push_back(t);
      e.idx = i; e.wr = wr; e.addr = a; e.wdata = wd;
      e.rdata = wr ? 32'h0 : slv(a);
      e.lat   = wr ? 2 : 2 + LAT[d];
      gq[d].push_back(e);
      bq[d].push_back(e);
      if (rsp) rq[d].push_back(e);
   endtask

   function automatic bit all_done();
      bit ok = 1'b1;
      for (int j = 0; j < 8; j++) if (sq[j].size() != 0 || act[j]) ok = 1'b0;
      for (int d = 0; d < 2; d++)
         if (gq[d].size() != 0 || bq[d].size() != 0 || rq[d].size() != 0) ok = 1'b0;
      return ok;
   endfunction

   task automatic wait_all(input int budget);
      for (int n = 0; n < budget; n++) begin
         @(posedge clk);
         if (all_done()) return;
      end
      chk("drain_timeout", 32'(rq[0].size() + rq[1].size() + gq[0].size() + gq[1].size()), 0);
   endtask

   task automatic wait_gq(input int d, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(posedge clk);
         if (gq[d].size() == 0) return;
      end
      chk("grant_timeout", 32'(gq[d].size()), 0);
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_d%0d_req_ready", tag, d), {28'h0, rdy[d]}, 0);
         chk($sformatf("%s_d%0d_rsp_valid", tag, d), {28'h0, rspv[d]}, 0);
         chk($sformatf("%s_d%0d_rsp_rdata", tag, d), rrd[d], 0);
         chk($sformatf("%s_d%0d_addr", tag, d), baddr[d], 0);
         chk($sformatf("%s_d%0d_wdata", tag, d), bwd[d], 0);
         chk($sformatf("%s_d%0d_wr_valid", tag, d), {30'h0, bwr[d], bval[d]}, 0);
      end
   endtask

   // Requester driver: samples req_ready before the edge, retires accepted
   // requests just after it and presents the next queued one.
   initial begin
      logic [3:0] rs [2];
      for (int d = 0; d < 2; d++) begin
         rv[d] = '0; rw[d] = '0; ra[d] = '0; rwd[d] = '0;
      end
      for (int j = 0; j < 8; j++) act[j] = 1'b0;
      forever begin
         @(negedge clk);
         rs[0] = rdy[0];
         rs[1] = rdy[1];
         @(posedge clk);
         #1;
         for (int j = 0; j < 8; j++) begin
            int d, i;
            txn_t t;
            d = j / 4;
            i = j % 4;
            if (act[j] && rs[d][i]) act[j] = 1'b0;
            if (rst_n && !act[j] && sq[j].size() != 0) begin
               t = sq[j].pop_front();
               act[j] = 1'b1;
               rw[d][i] = t.wr;
               ra[d][32*i +: 32]  = t.addr;
               rwd[d][32*i +: 32] = t.wdata;
            end
            rv[d][i] = act[j];
         end
      end
   end

   // Scoreboard monitor: completions first so a grant in the same cycle
   // sees the bus as free.
   initial begin
      busy[0] = 1'b0; busy[1] = 1'b0;
      acc[0] = 0; acc[1] = 0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               busy[d] = 1'b0;
               continue;
            end
            if (rspv[d] != 0) begin
               if (rq[d].size() == 0) begin
                  chk($sformatf("d%0d_rsp_unexpected", d), {28'h0, rspv[d]}, 0);
               end else begin
                  me = rq[d].pop_front();
                  chk($sformatf("d%0d_rsp_idx", d), {28'h0, rspv[d]}, 32'(1 << me.idx));
                  chk($sformatf("d%0d_rsp_rdata", d), rrd[d], me.rdata);
                  chk($sformatf("d%0d_rsp_latency", d), 32'(cyc - acc[d]), 32'(me.lat));
               end
               busy[d] = 1'b0;
            end
            if (bval[d]) begin
               if (bq[d].size() == 0) begin
                  chk($sformatf("d%0d_bus_unexpected", d), 1, 0);
               end else begin
                  me = bq[d].pop_front();
                  chk($sformatf("d%0d_bus_addr", d), baddr[d], me.addr);
                  chk($sformatf("d%0d_bus_wdata", d), bwd[d], me.wdata);
                  chk($sformatf("d%0d_bus_wr_en", d), {31'h0, bwr[d]}, {31'h0, me.wr});
                  chk($sformatf("d%0d_bus_delay", d), 32'(cyc - acc[d]), 1);
               end
            end
            if (rdy[d] != 0) begin
               chk($sformatf("d%0d_ready_while_busy", d), {31'h0, busy[d]}, 0);
               if (gq[d].size() == 0) begin
                  chk($sformatf("d%0d_grant_unexpected", d), {28'h0, rdy[d]}, 0);
               end else begin
                  me = gq[d].pop_front();
                  chk($sformatf("d%0d_grant_idx", d), {28'h0, rdy[d]}, 32'(1 << me.idx));
               end
               acc[d]  = cyc;
               busy[d] = 1'b1;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Contention on RD_LAT=1: 0,1,2,3 then requester 0 again.
      for (int i = 0; i < 4; i++)
         req(0, i, 1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b1);
      req(0, 0, 1'b1, 32'h1F0, 32'hA000_00F0, 1'b1);
      wait_all(200);

      // Single write then single read on RD_LAT=1.
      req(0, 1, 1'b1, 32'h10, 32'hA5A5_0001, 1'b1);
      wait_all(50);
      req(0, 0, 1'b0, 32'h20, 32'h0, 1'b1);
      wait_all(50);

      // RD_LAT=3 read with a competing write held off during WAIT_RD.
      req(1, 0, 1'b0, 32'h44, 32'h0, 1'b1);
      req(1, 1, 1'b1, 32'h48, 32'h1234_5678, 1'b1);
      wait_all(100);

      // Reset during WAIT_RD: in-flight read vanishes, requester 0 wins next.
      req(1, 1, 1'b0, 32'h30, 32'h0, 1'b0);
      wait_gq(1, 50);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("midread");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      req(1, 0, 1'b1, 32'h400, 32'h4444_0000, 1'b1);
      req(1, 2, 1'b1, 32'h408, 32'h4444_0002, 1'b1);
      wait_all(100);

      // Back-to-back alternating reads/writes from requesters 2 and 3.
      for (int k = 0; k < 8; k++) begin
         req(0, 2, (k % 2) == 0, 32'h200 + 32'(4*k), 32'h2200_0000 + 32'(k), 1'b1);
         req(0, 3, (k % 2) == 1, 32'h300 + 32'(4*k), 32'h3300_0000 + 32'(k), 1'b1);
      end
      wait_all(400);
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
